stim_pulse_gen: RTL and testbench

Charge-balanced biphasic stimulation pulse generator. It sits directly downstream of the detection controller: it consumes the controller's `stimulation` decision and turns it into timed cathodic/anodic electrode drive. Each accepted trigger produces a burst of N biphasic pulses followed by a refractory lockout, and amplitude is latched per burst.

---
 rtl/stim_pkg.sv | 27 ++
 rtl/stim_timer.sv | 17 +
 rtl/stim_pulse_gen.sv | 80 ++++++++
 tb/tb_stim_pulse_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// stim_pkg: state encoding, rest-length derivation and parameter legality for stim_pulse_gen
package stim_pkg;
  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_CATH    = 6'b000010;
  localparam logic [5:0] S_GAP     = 6'b000100;
  localparam logic [5:0] S_ANOD    = 6'b001000;
  localparam logic [5:0] S_REST    = 6'b010000;
  localparam logic [5:0] S_REFRACT = 6'b100000;
  typedef enum logic [5:0] {
    IDLE    = S_IDLE,
    CATH    = S_CATH,
    GAP     = S_GAP,
    ANOD    = S_ANOD,
    REST    = S_REST,
    REFRACT = S_REFRACT
  } state_t;
  function automatic int rest_len(input int period, input int phase, input int gap);
    return period - 2 * phase - gap;
  endfunction
  function automatic bit params_ok(input int cnt_w, input int phase, input int gap,
                                   input int period, input int n, input int refract);
    longint lim;
    lim = longint'(1) << cnt_w;
    return phase >= 1 && gap >= 1 && n >= 1 && refract >= 1 &&
           period > 2 * phase + gap && longint'(period) <= lim && longint'(refract) <= lim;
  endfunction
endpackage

// File: rtl/stim_timer.sv
// stim_timer: loadable down-counter with stall, flags zero when the current interval has expired
module stim_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  assign zero = cnt_q == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else if (!stall) cnt_q <= load ? load_val : zero ? cnt_q : cnt_q - W'(1);
endmodule

// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen: charge-balanced biphasic burst generator with refractory lockout
module stim_pulse_gen
  import stim_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int AMP_WIDTH    = 8,
  parameter int PHASE_LEN    = 100,
  parameter int GAP_LEN      = 20,
  parameter int PULSE_PERIOD = 1000,
  parameter int N_PULSES     = 5,
  parameter int REFRACT_LEN  = 10000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        trigger,
  input  logic [AMP_WIDTH-1:0]        amp,
  output logic                        stim_neg,
  output logic                        stim_pos,
  output logic signed [AMP_WIDTH:0]   dac_out,
  output logic                        busy,
  output logic                        burst_done
);
  localparam int PW = $clog2(N_PULSES + 1);
  localparam logic [CNT_WIDTH-1:0] PH_LD   = CNT_WIDTH'(PHASE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LD  = CNT_WIDTH'(GAP_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] REST_LD = CNT_WIDTH'(rest_len(PULSE_PERIOD, PHASE_LEN, GAP_LEN) - 1);
  localparam logic [CNT_WIDTH-1:0] REF_LD  = CNT_WIDTH'(REFRACT_LEN - 1);
  localparam logic [PW-1:0]        LAST    = PW'(N_PULSES - 1);
  if (!params_ok(CNT_WIDTH, PHASE_LEN, GAP_LEN, PULSE_PERIOD, N_PULSES, REFRACT_LEN)) begin : g_bad_params
    $error("stim_pulse_gen: illegal timing parameters");
  end
  state_t                state_q, state_d;
  logic [AMP_WIDTH-1:0]  amp_q;
  logic [PW-1:0]         pcnt_q;
  logic                  done_q, start, last, load, zero;
  logic [CNT_WIDTH-1:0]  load_val;
  assign start = state_q == IDLE && trigger;
  assign last  = pcnt_q == LAST;
  assign load  = state_d != state_q;
  stim_timer #(.W(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .stall    (en),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );
  // every transition reloads the shared timer with the length of the state being entered
  always_comb begin
    state_d  = state_q;
    load_val = '0;
    case (state_q)
      IDLE:    if (trigger) begin state_d = CATH; load_val = PH_LD; end
      CATH:    if (zero) begin state_d = GAP; load_val = GAP_LD; end
      GAP:     if (zero) begin state_d = ANOD; load_val = PH_LD; end
      ANOD:    if (zero) begin state_d = last ? REFRACT : REST; load_val = last ? REF_LD : REST_LD; end
      REST:    if (zero) begin state_d = CATH; load_val = PH_LD; end
      REFRACT: if (zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      amp_q   <= '0;
      pcnt_q  <= '0;
      done_q  <= 1'b0;
    end else if (!en) begin
      state_q <= state_d;
      amp_q   <= start ? amp : amp_q;
      pcnt_q  <= start ? '0 : (state_q == ANOD && state_d == REST) ? pcnt_q + PW'(1) : pcnt_q;
      done_q  <= state_q == ANOD && state_d == REFRACT;
    end
  assign stim_neg   = state_q == CATH;
  assign stim_pos   = state_q == ANOD;
  assign busy       = state_q != IDLE;
  assign burst_done = done_q;
  assign dac_out    = stim_neg ? -$signed({1'b0, amp_q}) : stim_pos ? $signed({1'b0, amp_q}) : '0;
endmodule

// File: tb/tb_stim_pulse_gen.sv
// tb_stim_pulse_gen: directed scenarios plus randomized traffic checked against a burst-offset model
module tb_stim_pulse_gen;
  localparam int PH = 4, GP = 2, PER = 16, NP = 3, RF = 20;
  localparam int BL  = (NP - 1) * PER + 2 * PH + GP;
  localparam int TOT = BL + RF;
  logic clk = 0, rst = 0, en = 0, trigger = 0;
  logic [7:0] amp = 0;
  logic stim_neg, stim_pos, busy, burst_done;
  logic signed [8:0] dac_out;
  int n_chk = 0, n_pass = 0, cyc = 0, base = 0;
  bit active_m = 0;
  int k_m = 0, amp_m = 0;

  stim_pulse_gen #(
    .CNT_WIDTH(16), .AMP_WIDTH(8), .PHASE_LEN(PH), .GAP_LEN(GP),
    .PULSE_PERIOD(PER), .N_PULSES(NP), .REFRACT_LEN(RF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .amp(amp),
    .stim_neg(stim_neg), .stim_pos(stim_pos), .dac_out(dac_out),
    .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  // model: a burst is a count k of non-stalled cycles since acceptance
  always @(posedge clk or negedge rst)
    if (!rst) begin
      active_m <= 0; k_m <= 0; amp_m <= 0;
    end else if (!en) begin
      if (!active_m) begin
        if (trigger) begin active_m <= 1; k_m <= 0; amp_m <= int'(amp); end
      end else begin
        k_m <= k_m + 1;
        if (k_m == TOT - 1) active_m <= 0;
      end
    end

  always @(negedge clk) begin
    int o;
    bit inb, e_neg, e_pos;
    o     = k_m % PER;
    inb   = active_m && k_m < BL;
    e_neg = inb && o < PH;
    e_pos = inb && o >= PH + GP && o < 2 * PH + GP;
    chk("m_stim_neg", int'(stim_neg), int'(e_neg));
    chk("m_stim_pos", int'(stim_pos), int'(e_pos));
    chk("m_dac_out", int'(dac_out), e_neg ? -amp_m : e_pos ? amp_m : 0);
    chk("m_busy", int'(busy), int'(active_m));
    chk("m_burst_done", int'(burst_done), int'(active_m && k_m == BL));
  end

  task automatic run_to(input int c);
    while (cyc - base < c) @(negedge clk);
  endtask

  task automatic start_scenario();
    @(negedge clk);
    base = cyc - 10;
  endtask

  task automatic wait_idle();
    int n = 0;
    trigger = 0;
    while (active_m && n < 300) begin @(negedge clk); n++; end
    chk("idle_timeout", int'(active_m), 0);
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_neg"}, int'(stim_neg), 0);
    chk({tag, "_pos"}, int'(stim_pos), 0);
    chk({tag, "_dac"}, int'(dac_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(burst_done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1;
    amp = 50;
    // single burst, mid-burst amp change, trigger during refractory
    start_scenario();
    trigger = 1;
    run_to(11); trigger = 0;
    chk("s1_neg11", int'(stim_neg), 1);
    chk("s1_busy11", int'(busy), 1);
    chk("s1_dac11", int'(dac_out), -50);
    run_to(15); chk("s1_neg15", int'(stim_neg), 0);
    run_to(17); chk("s1_pos17", int'(stim_pos), 1);
    chk("s1_dac17", int'(dac_out), 50);
    run_to(20); amp = 100;
    run_to(27); chk("s1_neg27", int'(stim_neg), 1);
    run_to(33); chk("s1_dac33", int'(dac_out), 50);
    run_to(52); chk("s1_pos52", int'(stim_pos), 1);
    run_to(53); chk("s1_done53", int'(burst_done), 1);
    run_to(54); chk("s1_done54", int'(burst_done), 0);
    run_to(60); trigger = 1;
    run_to(61); trigger = 0;
    run_to(72); chk("s1_busy72", int'(busy), 1);
    run_to(73); chk("s1_busy73", int'(busy), 0);
    run_to(76); chk("s1_busy76", int'(busy), 0);
    wait_idle();
    // trigger held: back-to-back bursts at the new amplitude
    start_scenario();
    trigger = 1;
    run_to(11); chk("s2_dac11", int'(dac_out), -100);
    run_to(73); chk("s2_neg73", int'(stim_neg), 0);
    run_to(74); chk("s2_neg74", int'(stim_neg), 1);
    chk("s2_dac74", int'(dac_out), -100);
    wait_idle();
    // stall for four cycles during the first cathodic phase
    amp = 50;
    start_scenario();
    trigger = 1;
    run_to(11); trigger = 0;
    run_to(12); en = 1;
    run_to(16); en = 0;
    run_to(18); chk("s5_neg18", int'(stim_neg), 1);
    run_to(19); chk("s5_neg19", int'(stim_neg), 0);
    run_to(56); chk("s5_done56", int'(burst_done), 0);
    run_to(57); chk("s5_done57", int'(burst_done), 1);
    wait_idle();
    // asynchronous reset during the anodic phase, restart without lockout
    start_scenario();
    trigger = 1;
    run_to(11); trigger = 0;
    run_to(18); chk("s4_pos18", int'(stim_pos), 1);
    #1 rst = 0;
    #1 chk_zero_outputs("s4_async");
    trigger = 1;
    run_to(20); rst = 1;
    run_to(21); chk("s4_neg21", int'(stim_neg), 1);
    chk("s4_busy21", int'(busy), 1);
    wait_idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      trigger = $urandom_range(0, 5) == 0;
      en      = $urandom_range(0, 9) == 0;
      amp     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 0;
        @(negedge clk);
        rst = 1;
      end
    end
    en = 0;
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
